// File: rtl/control_unit.sv
// Multicycle RISC-V control FSM: sequences fetch/decode/execute/writeback and
// drives the datapath strobes and mux selects from the current state.
module control_unit (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic       PC_write,
  output logic       address_src,
  output logic       IR_write,
  output logic       reg_write,
  output logic       mem_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_A,
  output logic [1:0] alu_src_B,
  output logic [1:0] imm_src,
  output logic [2:0] alu_control,
  output logic [3:0] state,
  output logic       illegal_instr,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  state_t     state_r;
  state_t     state_next;
  logic [2:0] func_alu;
  logic       pc_write_raw;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       illegal_raw;
  logic       done_raw;

  assign state = state_r;

  always_ff @(posedge clk) begin
    if (rst) state_r <= FETCH;
    else     state_r <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state_r)
      FETCH:    state_next = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default:      state_next = FETCH;
        endcase
      end
      MEMADR:   state_next = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  state_next = MEMWB;
      EXECUTER: state_next = ALUWB;
      EXECUTEI: state_next = ALUWB;
      JAL:      state_next = ALUWB;
      default:  state_next = FETCH;
    endcase
  end

  // funct7b5 only selects sub for register-register ops; addi ignores it.
  always_comb begin
    case (funct3)
      3'b000:  func_alu = (opcode[5] & funct7b5) ? ALU_SUB : ALU_ADD;
      3'b010:  func_alu = ALU_SLT;
      3'b110:  func_alu = ALU_OR;
      3'b111:  func_alu = ALU_AND;
      default: func_alu = ALU_ADD;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_SW:   imm_src = 2'b01;
      OP_BEQ:  imm_src = 2'b10;
      OP_JAL:  imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  always_comb begin
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    reg_write_raw = 1'b0;
    mem_write_raw = 1'b0;
    illegal_raw   = 1'b0;
    done_raw      = 1'b0;
    address_src   = 1'b0;
    result_src    = 2'd0;
    alu_src_A     = 2'd0;
    alu_src_B     = 2'd0;
    alu_control   = ALU_ADD;
    case (state_r)
      FETCH: begin
        ir_write_raw = 1'b1;
        pc_write_raw = 1'b1;
        alu_src_B    = 2'd2;
        result_src   = 2'd2;
      end
      DECODE: begin
        alu_src_A   = 2'd1;
        alu_src_B   = 2'd1;
        illegal_raw = !(opcode inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL});
      end
      MEMADR: begin
        alu_src_A = 2'd2;
        alu_src_B = 2'd1;
      end
      MEMREAD: address_src = 1'b1;
      MEMWB: begin
        result_src    = 2'd1;
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      MEMWRITE: begin
        address_src   = 1'b1;
        mem_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      EXECUTER: begin
        alu_src_A   = 2'd2;
        alu_control = func_alu;
      end
      EXECUTEI: begin
        alu_src_A   = 2'd2;
        alu_src_B   = 2'd1;
        alu_control = func_alu;
      end
      ALUWB: begin
        reg_write_raw = 1'b1;
        done_raw      = 1'b1;
      end
      BEQ: begin
        alu_src_A    = 2'd2;
        alu_control  = ALU_SUB;
        pc_write_raw = zero;
        done_raw     = 1'b1;
      end
      JAL: begin
        alu_src_A    = 2'd1;
        alu_src_B    = 2'd2;
        pc_write_raw = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are suppressed during reset so nothing architectural is written.
  assign PC_write      = pc_write_raw  & ~rst;
  assign IR_write      = ir_write_raw  & ~rst;
  assign reg_write     = reg_write_raw & ~rst;
  assign mem_write     = mem_write_raw & ~rst;
  assign illegal_instr = illegal_raw   & ~rst;
  assign instr_done    = done_raw      & ~rst;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: walks each instruction class state by state
// and compares the full output word against hand-built expected vectors.
module tb_control_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic       PC_write, address_src, IR_write, reg_write, mem_write;
  logic [1:0] result_src, alu_src_A, alu_src_B, imm_src;
  logic [2:0] alu_control;
  logic [3:0] state;
  logic       illegal_instr, instr_done;

  int n_cmp = 0;
  int n_err = 0;

  control_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3),
    .funct7b5(funct7b5), .zero(zero), .PC_write(PC_write),
    .address_src(address_src), .IR_write(IR_write), .reg_write(reg_write),
    .mem_write(mem_write), .result_src(result_src), .alu_src_A(alu_src_A),
    .alu_src_B(alu_src_B), .imm_src(imm_src), .alu_control(alu_control),
    .state(state), .illegal_instr(illegal_instr), .instr_done(instr_done)
  );

  always #5 clk = ~clk;

  logic [21:0] outs;
  assign outs = {PC_write, address_src, IR_write, reg_write, mem_write,
                 result_src, alu_src_A, alu_src_B, imm_src, alu_control,
                 illegal_instr, instr_done, state};

  function automatic logic [21:0] vec(
    input logic pcw, input logic adr, input logic irw, input logic rw,
    input logic mw, input logic [1:0] rs, input logic [1:0] sa,
    input logic [1:0] sb, input logic [1:0] imm, input logic [2:0] alu,
    input logic ill, input logic done, input logic [3:0] st);
    return {pcw, adr, irw, rw, mw, rs, sa, sb, imm, alu, ill, done, st};
  endfunction

  task automatic chk_eq(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%06h expected 0x%06h", tag, got, exp);
    end
  endtask

  // Compare on the falling edge, then advance to just after the next rising edge.
  task automatic step(input string tag, input logic [21:0] exp);
    @(negedge clk);
    chk_eq(tag, {10'd0, outs}, {10'd0, exp});
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z);
    opcode = op; funct3 = f3; funct7b5 = f7; zero = z;
  endtask

  initial begin
    rst = 1'b1;
    set_instr(7'b0000011, 3'b000, 1'b0, 1'b0);
    @(posedge clk); #1;
    step("rst_hold", vec(0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    rst = 1'b0;

    // lw
    step("lw_fetch",  vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("lw_decode", vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("lw_memadr", vec(0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0,3'd0, 0,0, 4'd2));
    step("lw_memrd",  vec(0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,0, 4'd3));
    step("lw_memwb",  vec(0,0,0,1,0, 2'd1,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd4));

    // sw
    set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
    step("sw_fetch",  vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd1,3'd0, 0,0, 4'd0));
    step("sw_decode", vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd1,3'd0, 0,0, 4'd1));
    step("sw_memadr", vec(0,0,0,0,0, 2'd0,2'd2,2'd1,2'd1,3'd0, 0,0, 4'd2));
    step("sw_memwr",  vec(0,1,0,0,1, 2'd0,2'd0,2'd0,2'd1,3'd0, 0,1, 4'd5));

    // R-type sub
    set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
    step("sub_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("sub_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("sub_exec",  vec(0,0,0,0,0, 2'd0,2'd2,2'd0,2'd0,3'd1, 0,0, 4'd6));
    step("sub_aluwb", vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));

    // addi with funct7b5=1 must still add
    set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
    step("addi_fetch",vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("addi_dec",  vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("addi_exec", vec(0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0,3'd0, 0,0, 4'd7));
    step("addi_aluwb",vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));

    // remaining function decodes, checked in the execute state
    set_instr(7'b0110011, 3'b110, 1'b0, 1'b0);
    step("or_fetch",  vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("or_decode", vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("or_exec",   vec(0,0,0,0,0, 2'd0,2'd2,2'd0,2'd0,3'd3, 0,0, 4'd6));
    step("or_aluwb",  vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));
    set_instr(7'b0110011, 3'b111, 1'b0, 1'b0);
    step("and_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("and_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("and_exec",  vec(0,0,0,0,0, 2'd0,2'd2,2'd0,2'd0,3'd2, 0,0, 4'd6));
    step("and_aluwb", vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));
    set_instr(7'b0010011, 3'b010, 1'b0, 1'b0);
    step("slti_fetch",vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("slti_dec",  vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("slti_exec", vec(0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0,3'd5, 0,0, 4'd7));
    step("slti_aluwb",vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));
    set_instr(7'b0110011, 3'b001, 1'b1, 1'b0);
    step("sll_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("sll_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("sll_exec",  vec(0,0,0,0,0, 2'd0,2'd2,2'd0,2'd0,3'd0, 0,0, 4'd6));
    step("sll_aluwb", vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,1, 4'd8));

    // beq taken, then not taken
    set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
    step("beqt_fetch",vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd2,3'd0, 0,0, 4'd0));
    step("beqt_dec",  vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd2,3'd0, 0,0, 4'd1));
    step("beqt_beq",  vec(1,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,3'd1, 0,1, 4'd9));
    zero = 1'b0;
    step("beqn_fetch",vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd2,3'd0, 0,0, 4'd0));
    step("beqn_dec",  vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd2,3'd0, 0,0, 4'd1));
    step("beqn_beq",  vec(0,0,0,0,0, 2'd0,2'd2,2'd0,2'd2,3'd1, 0,1, 4'd9));

    // jal
    set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
    step("jal_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd3,3'd0, 0,0, 4'd0));
    step("jal_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd3,3'd0, 0,0, 4'd1));
    step("jal_jal",   vec(1,0,0,0,0, 2'd0,2'd1,2'd2,2'd3,3'd0, 0,0, 4'd10));
    step("jal_aluwb", vec(0,0,0,1,0, 2'd0,2'd0,2'd0,2'd3,3'd0, 0,1, 4'd8));

    // illegal opcode
    set_instr(7'b1111111, 3'b000, 1'b0, 1'b0);
    step("ill_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("ill_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 1,0, 4'd1));

    // reset asserted mid-lw, while in MEMREAD
    set_instr(7'b0000011, 3'b000, 1'b0, 1'b0);
    step("rlw_fetch", vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("rlw_decode",vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));
    step("rlw_memadr",vec(0,0,0,0,0, 2'd0,2'd2,2'd1,2'd0,3'd0, 0,0, 4'd2));
    rst = 1'b1;
    step("rlw_memrd", vec(0,1,0,0,0, 2'd0,2'd0,2'd0,2'd0,3'd0, 0,0, 4'd3));
    step("rlw_rstfch",vec(0,0,0,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    rst = 1'b0;
    step("rlw_fetch2",vec(1,0,1,0,0, 2'd2,2'd0,2'd2,2'd0,3'd0, 0,0, 4'd0));
    step("rlw_dec2",  vec(0,0,0,0,0, 2'd0,2'd1,2'd1,2'd0,3'd0, 0,0, 4'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  input  1  rising-edge clock; single clock domain.
REQ-002 rst  input  1  synchronous, active-high reset; sampled on rising clk edge.
REQ-003 opcode  input  7  instr[6:0] from instruction register.
REQ-004 funct3  input  3  instr[14:12].
REQ-005 funct7b5  input  1  instr[30].
REQ-006 zero  input  1  high when combinational ALU result == 0.
REQ-007 PC_write, address_src, IR_write, reg_write, mem_write  output  1 each  datapath strobes/selects.
REQ-008 result_src, alu_src_A, alu_src_B, imm_src  output  2 each  mux selects. Encodings:
- alu_src_A: 0=PC, 1=old_PC, 2=A.
- alu_src_B: 0=B, 1=imm, 2=4.
- result_src: 0=alu_out, 1=data, 2=alu_result.
- address_src: 0=PC, 1=result.
REQ-009 alu_control  output  3  ALU op. Encodings: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-010 state  output  4  current FSM state; debug only.
REQ-011 illegal_instr  output  1  one-cycle pulse in DECODE on an unsupported opcode.
REQ-012 instr_done  output  1  one-cycle pulse in the final state of each instruction.

Function
REQ-013 The block SHALL be a Moore FSM: 4-bit state register, all outputs combinational from state plus decoded instruction fields.
REQ-014 States SHALL be FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10; codes 11-15 SHALL go to FETCH next cycle.
REQ-015 FETCH SHALL drive address_src=0, IR_write=1, alu_src_A=0, alu_src_B=2, alu_control=add, result_src=2, PC_write=1; next state is DECODE.
REQ-016 DECODE SHALL drive alu_src_A=1, alu_src_B=1, alu_control=add, which precomputes the branch/jump target into alu_out.
REQ-017 DECODE next state by opcode:
- 0000011 or 0100011 -> MEMADR.
- 0110011 -> EXECUTER.
- 0010011 -> EXECUTEI.
- 1100011 -> BEQ.
- 1101111 -> JAL.
- any other opcode -> FETCH, with illegal_instr=1.
REQ-018 MEMADR SHALL drive alu_src_A=2, alu_src_B=1, add; next state is MEMREAD if opcode=0000011, else MEMWRITE.
REQ-019 MEMREAD SHALL drive address_src=1, result_src=0; next state is MEMWB.
REQ-020 MEMWB SHALL drive result_src=1, reg_write=1, instr_done=1; next state is FETCH.
REQ-021 MEMWRITE SHALL drive address_src=1, result_src=0, mem_write=1, instr_done=1; next state is FETCH.
REQ-022 EXECUTER SHALL drive alu_src_A=2, alu_src_B=0; EXECUTEI SHALL drive alu_src_A=2, alu_src_B=1; both use the function-decoded alu_control and go to ALUWB.
REQ-023 ALUWB SHALL drive result_src=0, reg_write=1, instr_done=1; next state is FETCH.
REQ-024 BEQ SHALL drive alu_src_A=2, alu_src_B=0, sub, result_src=0; PC_write=zero; instr_done=1; next state is FETCH.
REQ-025 JAL SHALL drive alu_src_A=1, alu_src_B=2, add, result_src=0, PC_write=1; next state is ALUWB, which writes the link address to rd.
REQ-026 Function decode SHALL be:
- funct3 000 -> sub if (opcode[5] & funct7b5), else add.
- funct3 010 -> slt; 110 -> or; 111 -> and.
- any other funct3 -> add.
REQ-027 imm_src SHALL decode from opcode in every state: 0100011 -> 01 (S), 1100011 -> 10 (B), 1101111 -> 11 (J), all others -> 00 (I).
REQ-028 Every output not listed for a state SHALL be 0.
REQ-029 Cycle counts SHALL be lw 5, sw 4, R/I 4, beq 3, jal 4, illegal 2.

Reset
REQ-030 With rst=1 at a rising edge, state SHALL become FETCH, regardless of the current state, including mid-instruction.
REQ-031 While rst=1, PC_write, IR_write, reg_write, mem_write, illegal_instr and instr_done SHALL be forced to 0; mux selects follow state.
REQ-032 The first cycle after rst deasserts SHALL be a full FETCH.

Verification
REQ-033 lw (opcode 0000011) after reset -> states 0,1,2,3,4,0; reg_write=1 only in state 4; result_src=1 there.
REQ-034 sw (0100011) -> states 0,1,2,5,0; mem_write=1 and address_src=1 for exactly one cycle; imm_src=01.
REQ-035 R-type with funct3=000, funct7b5=1 -> alu_control=001 in EXECUTER; the same fields with opcode 0010011 -> 000 (addi).
REQ-036 beq with zero=1 -> PC_write=1 in state 9; with zero=0 -> PC_write=0; both return to FETCH.
REQ-037 jal -> states 0,1,10,8,0; PC_write=1 in 10; reg_write=1 in 8; imm_src=11.
REQ-038 opcode 1111111 -> illegal_instr pulses in DECODE, then FETCH. rst=1 asserted in MEMREAD -> next state FETCH with no reg_write.
